// File: rtl/jtbubl_bram_sdram_pkg.sv
// Shared types and constants for the block-RAM stand-in for the JTBUBL SDRAM port.
// Holds the FSM encoding, the minimum read latency and the 32-bit read word layout.
package jtbubl_bram_sdram_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_ACK  = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_RD_DONE = 3'd3,
    ST_WR      = 3'd4,
    ST_WR_ACK  = 3'd5,
    ST_REFRESH = 3'd6
  } state_t;

  localparam int MIN_LAT = 3;

  localparam int LO_LSB = 0;
  localparam int LO_MSB = 15;
  localparam int HI_LSB = 16;
  localparam int HI_MSB = 31;

  function automatic int clamp_min(input int v, input int lo);
    return (v < lo) ? lo : v;
  endfunction

endpackage

// File: rtl/jtbubl_sdram_mem.sv
// Single-port 2^AW x 16 RAM, byte-lane write enables, registered read (1-cycle latency).
// Read-first: o_q shows the old word when a write hits the same address.
module jtbubl_sdram_mem #(
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic [AW-1:0] i_addr,
  input  logic [1:0]    i_we,
  input  logic [15:0]   i_din,
  output logic [15:0]   o_q
);

  logic [15:0] r_mem [0:(2**AW)-1];

  always_ff @(posedge clk) begin
    if (i_we[0]) r_mem[i_addr][7:0]  <= i_din[7:0];
    if (i_we[1]) r_mem[i_addr][15:8] <= i_din[15:8];
    o_q <= r_mem[i_addr];
  end

endmodule

// File: rtl/jtbubl_bram_sdram.sv
// SDRAM request/ack responder backed by on-chip RAM: 32-bit reads, 16-bit download
// writes, refresh windows and programmable read latency.
//
// state      | meaning
// IDLE       | waiting; arbitrates write > refresh > read
// RD_ACK     | sdram_ack pulse, lower word address presented to RAM
// RD_WAIT    | upper word fetched, latency timer running
// RD_DONE    | data_rdy pulse; also arbitrates so back-to-back reads cost LAT+1
// WR         | RAM write with prog_* inputs
// WR_ACK     | write latency timer, sdram_ack on terminal count
// REFRESH    | refresh window, REF_CYCLES long
module jtbubl_bram_sdram
  import jtbubl_bram_sdram_pkg::*;
#(
  parameter int AW         = 16,
  parameter int LAT        = 4,
  parameter int WR_LAT     = 2,
  parameter int REF_PERIOD = 384,
  parameter int REF_CYCLES = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sdram_req,
  input  logic [21:0] sdram_addr,
  output logic        sdram_ack,
  output logic        data_rdy,
  output logic [31:0] data_read,
  input  logic        refresh_en,
  input  logic        downloading,
  input  logic        prog_we,
  input  logic [21:0] prog_addr,
  input  logic [7:0]  prog_data,
  input  logic [1:0]  prog_mask,
  output logic        busy
);

  localparam int LAT_E    = clamp_min(LAT, MIN_LAT);
  localparam int WR_LAT_E = clamp_min(WR_LAT, 1);
  localparam int REF_CY_E = clamp_min(REF_CYCLES, 1);
  localparam int CW       = $clog2(LAT_E + WR_LAT_E + REF_CY_E + 1);
  localparam int RW       = $clog2(REF_PERIOD + 2);

  state_t          r_st;
  logic [CW-1:0]   r_cnt;
  logic [RW-1:0]   r_ref;
  logic [AW-1:0]   r_addr;
  logic [15:0]     r_lo;
  logic [31:0]     r_data;

  logic [AW-1:0]   w_mem_addr;
  logic [1:0]      w_mem_we;
  logic [15:0]     w_q;
  logic            w_dl_wr;
  logic            w_ref_due;
  logic            w_rd_go;
  logic            w_cnt_zero;
  logic            w_unused;

  assign w_dl_wr    = downloading & prog_we;
  assign w_ref_due  = refresh_en & (r_ref == RW'(REF_PERIOD));
  assign w_rd_go    = ~downloading & sdram_req;
  assign w_cnt_zero = (r_cnt == '0);
  assign w_unused   = &{1'b0, sdram_addr[21:AW], prog_addr[21:AW]};

  always_comb begin
    w_mem_addr = r_addr + AW'(1);
    w_mem_we   = 2'b00;
    if (r_st == ST_WR) begin
      w_mem_addr = prog_addr[AW-1:0];
      w_mem_we   = ~prog_mask;
    end else if (r_st == ST_RD_ACK) begin
      w_mem_addr = r_addr;
    end
  end

  jtbubl_sdram_mem #(.AW(AW)) u_mem (
    .clk    (clk),
    .i_addr (w_mem_addr),
    .i_we   (w_mem_we),
    .i_din  ({prog_data, prog_data}),
    .o_q    (w_q)
  );

  // Refresh counter: saturates at REF_PERIOD, frozen inside the window, cleared on exit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ref <= '0;
    end else if (!refresh_en) begin
      r_ref <= '0;
    end else if (r_st == ST_REFRESH) begin
      if (w_cnt_zero) r_ref <= '0;
    end else if (r_ref != RW'(REF_PERIOD)) begin
      r_ref <= r_ref + RW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_st   <= ST_IDLE;
      r_cnt  <= '0;
      r_addr <= '0;
      r_lo   <= '0;
      r_data <= '0;
    end else begin
      case (r_st)
        ST_IDLE, ST_RD_DONE: begin
          if (w_dl_wr) begin
            r_st <= ST_WR;
          end else if (w_ref_due) begin
            r_st  <= ST_REFRESH;
            r_cnt <= CW'(REF_CY_E - 1);
          end else if (w_rd_go) begin
            r_st   <= ST_RD_ACK;
            r_addr <= sdram_addr[AW-1:0];
          end else begin
            r_st <= ST_IDLE;
          end
        end
        ST_RD_ACK: begin
          r_st  <= ST_RD_WAIT;
          r_cnt <= CW'(LAT_E - 2);
        end
        ST_RD_WAIT: begin
          // First wait cycle carries the lower word; later ones hold the upper word.
          if (r_cnt == CW'(LAT_E - 2)) r_lo <= w_q;
          if (w_cnt_zero) begin
            r_st                   <= ST_RD_DONE;
            r_data[HI_MSB:HI_LSB]  <= w_q;
            r_data[LO_MSB:LO_LSB]  <= (r_cnt == CW'(LAT_E - 2)) ? w_q : r_lo;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        ST_WR: begin
          r_st  <= ST_WR_ACK;
          r_cnt <= CW'(WR_LAT_E - 1);
        end
        ST_WR_ACK, ST_REFRESH: begin
          if (w_cnt_zero) r_st  <= ST_IDLE;
          else            r_cnt <= r_cnt - CW'(1);
        end
        default: r_st <= ST_IDLE;
      endcase
    end
  end

  assign sdram_ack = (r_st == ST_RD_ACK) | ((r_st == ST_WR_ACK) & w_cnt_zero);
  assign data_rdy  = (r_st == ST_RD_DONE);
  assign data_read = r_data;
  assign busy      = (r_st != ST_IDLE);

endmodule

// File: tb/tb_jtbubl_bram_sdram.sv
// Directed + randomized bench for jtbubl_bram_sdram with a word-array reference model.
module tb_jtbubl_bram_sdram;

  localparam int AW         = 16;
  localparam int LAT        = 4;
  localparam int WR_LAT     = 2;
  localparam int REF_PERIOD = 384;
  localparam int REF_CYCLES = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sdram_req = 1'b0;
  logic [21:0] sdram_addr = '0;
  logic        sdram_ack;
  logic        data_rdy;
  logic [31:0] data_read;
  logic        refresh_en = 1'b0;
  logic        downloading = 1'b0;
  logic        prog_we = 1'b0;
  logic [21:0] prog_addr = '0;
  logic [7:0]  prog_data = '0;
  logic [1:0]  prog_mask = 2'b11;
  logic        busy;

  int          checks = 0;
  int          errors = 0;
  longint      cyc = 0;
  logic        overlap_seen = 1'b0;
  logic [15:0] mdl [0:65535];

  jtbubl_bram_sdram #(
    .AW(AW), .LAT(LAT), .WR_LAT(WR_LAT), .REF_PERIOD(REF_PERIOD), .REF_CYCLES(REF_CYCLES)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sdram_req   (sdram_req),
    .sdram_addr  (sdram_addr),
    .sdram_ack   (sdram_ack),
    .data_rdy    (data_rdy),
    .data_read   (data_read),
    .refresh_en  (refresh_en),
    .downloading (downloading),
    .prog_we     (prog_we),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .prog_mask   (prog_mask),
    .busy        (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (sdram_ack && data_rdy) overlap_seen <= 1'b1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // which: 0 = sdram_ack, 1 = data_rdy, 2 = busy. n = cycles stepped (budget+1 on timeout).
  task automatic wait_for(input int which, input int budget, output int n);
    logic s;
    n = 0;
    for (int i = 0; i < budget; i++) begin
      step();
      n++;
      case (which)
        0:       s = sdram_ack;
        1:       s = data_rdy;
        default: s = busy;
      endcase
      if (s) return;
    end
    n = budget + 1;
  endtask

  function automatic logic [31:0] exp_rd(input logic [21:0] a);
    int lo_a, hi_a;
    lo_a = int'(a) % 65536;
    hi_a = (int'(a) + 1) % 65536;
    return {mdl[hi_a], mdl[lo_a]};
  endfunction

  task automatic do_write(input logic [21:0] a, input logic [7:0] d, input logic [1:0] m);
    int n;
    int ia;
    downloading = 1'b1;
    prog_we     = 1'b1;
    prog_addr   = a;
    prog_data   = d;
    prog_mask   = m;
    wait_for(0, 10, n);
    chk("wr_ack_latency", n, 1 + WR_LAT);
    prog_we = 1'b0;
    ia = int'(a) % 65536;
    if (!m[0]) mdl[ia][7:0]  = d;
    if (!m[1]) mdl[ia][15:8] = d;
    step();
  endtask

  // Returns the cycle stamp of the ack; leaves the bench in the data_rdy cycle.
  task automatic do_read(input logic [21:0] a, output longint t_ack);
    int n;
    sdram_req  = 1'b1;
    sdram_addr = a;
    wait_for(0, 20, n);
    chk("rd_ack_latency", n, 1);
    t_ack     = cyc;
    sdram_req = 1'b0;
    wait_for(1, 20, n);
    chk("rd_rdy_latency", n, LAT);
    chk("rd_data", data_read, exp_rd(a));
  endtask

  initial begin
    longint t1, t2;
    int     n, k, first_idle;
    logic   seen;
    logic [21:0] ra;

    // Reset state
    #2;
    chk("reset_ack", {31'd0, sdram_ack}, 32'd0);
    chk("reset_rdy", {31'd0, data_rdy}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_data", data_read, 32'd0);
    step();
    step();
    rst_n = 1'b1;
    step();

    // Preload via download
    do_write(22'h10, 8'hAB, 2'b10);
    do_write(22'h10, 8'hCD, 2'b01);
    do_write(22'h11, 8'h34, 2'b00);
    do_write(22'hFFFF, 8'($urandom), 2'b00);
    do_write(22'h0000, 8'($urandom), 2'b00);
    do_write(22'h0005, 8'($urandom), 2'b00);
    do_write(22'h0006, 8'($urandom), 2'b00);
    for (int i = 0; i < 16; i++) do_write(22'h100 + 22'(i), 8'($urandom), 2'b00);
    for (int i = 0; i < 12; i++)
      do_write(22'h100 + 22'($urandom_range(0, 15)), 8'($urandom), 2'($urandom));
    downloading = 1'b0;
    step();

    // Read latency and back-to-back spacing
    do_read(22'h10, t1);
    chk("preload_word", data_read, 32'h3434_CDAB);
    do_read(22'h10, t2);
    chk("b2b_ack_spacing", 32'(t2 - t1), LAT + 1);

    // Wrap-around and aliasing
    do_read(22'h00FFFF, t1);
    do_read(22'h030005, t1);
    chk("alias_0005", data_read, {mdl[6], mdl[5]});

    // Randomized reads with random gaps and aliased upper bits
    for (int i = 0; i < 16; i++) begin
      k = $urandom_range(0, 2);
      for (int j = 0; j < k; j++) step();
      ra = {6'($urandom), 16'h0100 + 16'($urandom_range(0, 14))};
      do_read(ra, t1);
    end
    step();

    // Refresh disabled: no window
    seen = 1'b0;
    for (int i = 0; i < REF_PERIOD + 50; i++) begin
      step();
      if (busy) seen = 1'b1;
    end
    chk("no_refresh_when_disabled", {31'd0, seen}, 32'd0);

    // Refresh window with a read raised inside it
    refresh_en = 1'b1;
    wait_for(2, REF_PERIOD + 20, n);
    chk("refresh_start", n, REF_PERIOD + 1);
    step();
    step();
    sdram_req  = 1'b1;
    sdram_addr = 22'h10;
    k = 2;
    first_idle = -1;
    for (int i = 0; i < 20; i++) begin
      step();
      k++;
      if (!busy && first_idle < 0) first_idle = k;
      if (sdram_ack) break;
    end
    chk("refresh_length", first_idle, REF_CYCLES);
    chk("ack_after_refresh", k, REF_CYCLES + 1);
    sdram_req = 1'b0;
    wait_for(1, 20, n);
    chk("refresh_rd_rdy", n, LAT);
    chk("refresh_rd_data", data_read, 32'h3434_CDAB);
    refresh_en = 1'b0;
    step();

    // Download blocks reads
    downloading = 1'b1;
    sdram_req   = 1'b1;
    sdram_addr  = 22'h100;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (sdram_ack) seen = 1'b1;
    end
    chk("no_ack_while_downloading", {31'd0, seen}, 32'd0);
    downloading = 1'b0;
    wait_for(0, 10, n);
    chk("ack_after_download_drop", n, 1);
    sdram_req = 1'b0;
    wait_for(1, 20, n);
    chk("blocked_rd_data", data_read, exp_rd(22'h100));
    step();

    // Simultaneous write and read during download: write first
    sdram_req  = 1'b1;
    sdram_addr = 22'h104;
    do_write(22'h105, 8'($urandom), 2'b00);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (sdram_ack) seen = 1'b1;
    end
    chk("read_waits_for_write", {31'd0, seen}, 32'd0);
    downloading = 1'b0;
    wait_for(0, 10, n);
    chk("read_after_write_ack", n, 1);
    sdram_req = 1'b0;
    wait_for(1, 20, n);
    chk("read_sees_new_write", data_read, exp_rd(22'h104));
    step();

    // Async reset during RD_WAIT
    sdram_req  = 1'b1;
    sdram_addr = 22'h10;
    wait_for(0, 10, n);
    chk("pre_reset_ack", n, 1);
    sdram_req = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    #1;
    chk("rst_mid_ack", {31'd0, sdram_ack}, 32'd0);
    chk("rst_mid_rdy", {31'd0, data_rdy}, 32'd0);
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_data", data_read, 32'd0);
    step();
    step();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (sdram_ack || data_rdy) seen = 1'b1;
    end
    chk("no_pulse_after_reset", {31'd0, seen}, 32'd0);
    do_read(22'h10, t1);
    chk("mem_survives_reset", data_read, 32'h3434_CDAB);
    step();

    chk("ack_rdy_exclusive", {31'd0, overlap_seen}, 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
